seg_scan_scheduler: RTL and testbench

//  Multiplexed scan controller for the 4-digit common-anode 7-segment display.

---
 rtl/seg_scan_scheduler_if.sv | 27 ++
 rtl/seg_scan_scheduler.sv | 145 ++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_scheduler_if.sv
// Bus between system logic and the 7-segment scan scheduler.
//   master: system side; drives en/load/data_in/dp_in/blank_in/bright and
//           observes load_ready plus the display pins an/seg/dp and frame_done.
//   slave : the scheduler itself.
interface seg_scan_scheduler_if;
  logic        en;
  logic        load;
  logic        load_ready;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [2:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output en, load, data_in, dp_in, blank_in, bright,
    input  load_ready, an, seg, dp, frame_done
  );

  modport slave (
    input  en, load, data_in, dp_in, blank_in, bright,
    output load_ready, an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Scans one digit per TICK_DIV-cycle slot, decodes hex, applies per-digit
// blanking and decimal points, and dims with 8-level PWM. New data is held in
// a shadow buffer and copied to the active buffer only at a frame boundary
// (or immediately while the display is off), so a frame never tears.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : seg_scan_scheduler_if.slave
//              en, load/load_ready handshake, data_in/dp_in/blank_in payload,
//              bright (live PWM level), an/seg/dp pins (active-low),
//              frame_done (1-cycle pulse after slot 3 ends)
module seg_scan_scheduler #(
  parameter int unsigned TICK_DIV = 1024
) (
  input logic           clk,
  input logic           rst,
  seg_scan_scheduler_if.slave bus
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned SH = CW - 3;

  typedef enum logic {ST_OFF, ST_SCAN} state_t;

  state_t        state;
  logic [CW-1:0] cyc;
  logic [1:0]    slot;

  logic [15:0]   act_data, sh_data;
  logic [3:0]    act_dp, act_blank, sh_dp, sh_blank;

  logic          ready_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          fd_q;

  logic          last_cyc_c;
  logic          boundary_c;
  logic          commit_c;
  logic          accept_c;
  logic          lit_c;
  logic [3:0]    nibble_c;
  logic [CW:0]   on_len_c;

  // Active-low gfedcba hex decode
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Slot timing, buffer transfer and PWM decisions for the current cycle
  always_comb begin
    last_cyc_c = (cyc == CW'(TICK_DIV - 1));
    boundary_c = (state == ST_SCAN) && last_cyc_c && (slot == 2'd3);
    // Pending data moves to the active buffer at a frame end, or at once while dark
    commit_c   = !ready_q && ((state == ST_OFF) || boundary_c);
    accept_c   = bus.load && ready_q;
    nibble_c   = act_data[{slot, 2'b00} +: 4];
    // On-time in cycles: (bright+1) eighths of a slot
    on_len_c   = (CW+1)'({1'b0, bus.bright} + 4'd1) << SH;
    lit_c      = (state == ST_SCAN) && !act_blank[slot] && ({1'b0, cyc} < on_len_c);
  end

  // Scan FSM, buffers, handshake and registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      cyc       <= '0;
      slot      <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      act_blank <= 4'hF;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_blank  <= 4'hF;
      ready_q   <= 1'b1;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      if (!bus.en) begin
        state <= ST_OFF;
        cyc   <= '0;
        slot  <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            state <= ST_SCAN;
            cyc   <= '0;
            slot  <= '0;
          end
          default: begin
            // TICK_DIV is a power of two, so cyc wraps on its own
            cyc <= cyc + CW'(1);
            if (last_cyc_c) slot <= slot + 2'd1;
          end
        endcase
      end

      fd_q <= boundary_c;

      // commit and accept are exclusive: accept needs ready, commit needs pending
      if (commit_c) begin
        act_data  <= sh_data;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        ready_q   <= 1'b1;
      end else if (accept_c) begin
        sh_data  <= bus.data_in;
        sh_dp    <= bus.dp_in;
        sh_blank <= bus.blank_in;
        ready_q  <= 1'b0;
      end

      an_q  <= lit_c ? ~(4'b0001 << slot) : 4'hF;
      seg_q <= hex7(nibble_c);
      dp_q  <= ~act_dp[slot];
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a time-based behavioural model of the display.
module tb_seg_scan_scheduler;

  localparam int unsigned TD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_scheduler_if bus();

  seg_scan_scheduler #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: time since scanning began, plus both buffers
  bit          m_on;
  int unsigned m_t;
  bit          m_pend;
  bit          m_acc;
  logic [15:0] ma_data, ms_data;
  logic [3:0]  ma_dp, ma_blank, ms_dp, ms_blank;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd, e_ready;
  logic [6:0]  hex_tbl [16];

  initial begin
    hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    int unsigned cyc, slot, on_len;
    bit lit, bnd, commit;
    m_acc = 1'b0;
    if (rst) begin
      m_on = 0; m_t = 0; m_pend = 0;
      ma_data = '0; ma_dp = '0; ma_blank = 4'hF;
      ms_data = '0; ms_dp = '0; ms_blank = 4'hF;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_ready = 1'b1;
      return;
    end
    cyc    = m_t % TD;
    slot   = (m_t / TD) % 4;
    on_len = (int'(bus.bright) + 1) * TD / 8;
    lit    = m_on && !ma_blank[slot] && (cyc < on_len);
    e_an   = 4'hF;
    if (lit) e_an[slot] = 1'b0;
    e_seg  = hex_tbl[(ma_data >> (4 * slot)) & 16'hF];
    e_dp   = ~ma_dp[slot];
    bnd    = m_on && (cyc == TD - 1) && (slot == 3);
    e_fd   = bnd;
    commit = m_pend && (!m_on || bnd);
    if (commit) begin
      ma_data = ms_data; ma_dp = ms_dp; ma_blank = ms_blank; m_pend = 0;
    end else if (bus.load && !m_pend) begin
      ms_data = bus.data_in; ms_dp = bus.dp_in; ms_blank = bus.blank_in;
      m_pend = 1; m_acc = 1'b1;
    end
    if (!bus.en) begin
      m_on = 0; m_t = 0;
    end else if (!m_on) begin
      m_on = 1; m_t = 0;
    end else begin
      m_t++;
    end
    e_ready = !m_pend;
  endtask

  // Run n cycles, checking every output #1 after each rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      chk("an",         16'(bus.an),         16'(e_an));
      chk("seg",        16'(bus.seg),        16'(e_seg));
      chk("dp",         16'(bus.dp),         16'(e_dp));
      chk("frame_done", 16'(bus.frame_done), 16'(e_fd));
      chk("load_ready", 16'(bus.load_ready), 16'(e_ready));
      // Requester holds load until it has been accepted
      if (m_acc) bus.load = 1'b0;
    end
  endtask

  task automatic req(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bus.data_in  = d;
    bus.dp_in    = p;
    bus.blank_in = b;
    bus.load     = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.load     = 1'b0;
    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.blank_in = '0;
    bus.bright   = 3'd7;

    // Reset values, then dark until the first commit
    step(3);
    rst = 1'b0;
    step(40);

    // Basic frame at full brightness
    req(16'h1234, 4'h0, 4'h0);
    step(100);

    // PWM dimming
    bus.bright = 3'd1;
    step(40);
    bus.bright = 3'd0;
    step(40);
    bus.bright = 3'd7;

    // Blanking and decimal point
    req(16'hABCD, 4'b0001, 4'b0100);
    step(80);

    // Second load while pending is held off until after the commit
    req(16'h5678, 4'h0, 4'h0);
    step(3);
    req(16'h9ABC, 4'b1010, 4'h0);
    step(90);

    // en=0 mid-frame commits the pending value
    req(16'hFEDC, 4'h3, 4'h0);
    step(10);
    bus.en = 1'b0;
    step(5);
    bus.en = 1'b1;
    step(50);

    // rst mid-frame drops pending data
    req(16'h0F0F, 4'hF, 4'h0);
    step(12);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(50);

    // Random traffic
    repeat (3000) begin
      if ($urandom_range(0, 99) < 2) bus.en = ~bus.en;
      if ($urandom_range(0, 49) == 0) bus.bright = 3'($urandom);
      if (!bus.load && $urandom_range(0, 19) == 0)
        req(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0;
    step(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
